// File: rtl/seg_scan_scheduler.sv
// Four-digit multiplexed 7-segment scanner with guard blanking and frame-atomic updates.
// Optional: SEG_LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
module seg_scan_scheduler #(
  parameter int DWELL = 4096,
  parameter int GUARD = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_start
);

  localparam int MX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW = $clog2(MX) + 1;
  localparam logic [CW-1:0] G_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GUARD,
    S_DRIVE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [1:0]      idx, idx_nx;
  logic [6:0]      seg_nx;
  logic [3:0]      an_nx;
  logic            fs_nx;
  logic [15:0]     disp;
  logic [15:0]     pend;
  logic            pend_flag;
  logic            blank;
  logic [3:0]      nib;
  logic            hs;
  logic            commit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h00;
    unique case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
    endcase
    return s;
  endfunction

  assign nib = disp[{idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and everything above it is zero.
  always_comb begin
    blank = 1'b0;
    unique case (idx)
      2'd0: blank = 1'b0;
      2'd1: blank = (disp[15:4] == 12'h000);
      2'd2: blank = (disp[15:8] == 8'h00);
      2'd3: blank = (disp[15:12] == 4'h0);
    endcase
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    seg_nx   = 7'h00;
    an_nx    = 4'h0;
    fs_nx    = 1'b0;
    if (!enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = 2'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          state_nx = S_GUARD;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
          fs_nx    = 1'b1;
        end
        S_GUARD: begin
          if (cnt == G_LAST) begin
            state_nx = S_DRIVE;
            cnt_nx   = '0;
            an_nx    = 4'b0001 << idx;
            seg_nx   = blank ? 7'h00 : hex7(nib);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        S_DRIVE: begin
          if (cnt == D_LAST) begin
            state_nx = S_GUARD;
            cnt_nx   = '0;
            idx_nx   = idx + 2'd1;
            fs_nx    = (idx == 2'd3);
          end else begin
            cnt_nx = cnt + CW'(1);
            an_nx  = an;
            seg_nx = seg;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          idx_nx   = 2'd0;
        end
      endcase
    end
  end

  assign upd_ready = !pend_flag;
  assign hs        = upd_valid && !pend_flag;
  // Commit only at a frame boundary so all four digits show one value.
  assign commit    = pend_flag && ((state == S_IDLE) || fs_nx);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= 2'd0;
      seg         <= 7'h00;
      an          <= 4'h0;
      frame_start <= 1'b0;
      disp        <= 16'h0000;
      pend        <= 16'h0000;
      pend_flag   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      seg         <= seg_nx;
      an          <= an_nx;
      frame_start <= fs_nx;
      if (hs) begin
        pend      <= upd_data;
        pend_flag <= 1'b1;
      end
      if (commit) begin
        disp      <= pend;
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/seg_scan_scheduler.md
SEG_SCAN_SCHEDULER -- requirements
Module: seg_scan_scheduler

Interface
REQ-001 Parameter: DWELL, 4096, cycles each digit is driven per visit (>=1).
REQ-002 Parameter: GUARD, 64, blanking cycles before each digit (>=1).
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: enable  input  1  scanning allowed while high.
REQ-006 Port: upd_valid  input  1  new display value offered.
REQ-007 Port: upd_data  input  16  four hex nibbles; [3:0]=digit 0 (least significant) .. [15:12]=digit 3.
REQ-008 Port: upd_ready  output  1  update accepted when upd_valid & upd_ready at a rising edge.
REQ-009 Port: seg  output  7  segment drive, active-high, bit0=a .. bit6=g.
REQ-010 Port: an  output  4  digit enable, one-hot active-high, bit n=digit n.
REQ-011 Port: frame_start  output  1  one-cycle pulse at the start of each scan frame.

Function
REQ-012 States IDLE, GUARD, DRIVE. All outputs registered; they change on the same edge as the state.
REQ-013 IDLE: an=0, seg=0, digit index=0. enable=1 moves to GUARD for digit 0.
REQ-014 GUARD: an=0, seg=0 for exactly GUARD cycles, then DRIVE.
REQ-015 DRIVE: an=one-hot(index), seg=decode(display nibble[index]) for exactly DWELL cycles, then GUARD for index+1.
REQ-016 Index wraps 3->0. Frame period is 4*(GUARD+DWELL) cycles.
REQ-017 frame_start is high for the single cycle in which GUARD for digit 0 is entered, including entry from IDLE.
REQ-018 enable=0 in any state: next edge goes to IDLE with an=0, seg=0, index=0. No partial dwell is kept.
REQ-019 Decode (hex digit -> seg hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 Update path: a pending register plus a pending flag. upd_ready = !pending_flag.
REQ-021 A handshake captures upd_data into the pending register and sets the flag.
REQ-022 The pending value is copied to the display register on the frame_start edge, or on the next edge while in IDLE. The flag clears on the same edge.
REQ-023 The display never changes mid-frame. There are no torn updates across the four digits.
REQ-024 Handshake and commit in the same cycle cannot occur, because upd_ready=0 while pending. upd_ready returns high the cycle after commit.
REQ-025 upd_valid without upd_ready is ignored. The source holds data until accepted.

Reset
REQ-026 Reset has priority over all inputs.
REQ-027 Reset values: state=IDLE, seg=0, an=0, frame_start=0, upd_ready=1, index=0, all counters=0, display register=16'h0000, pending flag=0.
REQ-028 A pending update present at reset is discarded.

Configuration
REQ-029 Macro SEG_LEADING_ZERO_BLANK_EN.
REQ-030 With SEG_LEADING_ZERO_BLANK_EN defined, digits 3..1 above the most significant non-zero nibble drive seg=0 while an stays asserted. Digit 0 is always decoded.
REQ-031 Without SEG_LEADING_ZERO_BLANK_EN, every digit is decoded per REQ-019.

Verification (bench uses DWELL=4, GUARD=2)
REQ-032 Hold reset 3 cycles -> seg=0, an=0, upd_ready=1, frame_start=0.
REQ-033 In IDLE, offer 16'h1234, then raise enable. After the GUARD cycles -> an=0001 with seg=66 for 4 cycles, then 2 blank cycles, an=0010 with seg=4F, then an=0100 with seg=5B, then an=1000 with seg=06. frame_start pulses every 24 cycles.
REQ-034 Offer 16'hABCD during digit 1 of a frame -> upd_ready drops, digits 2 and 3 still show old values, and after the next frame_start digit 0 shows seg=5E. upd_ready is high one cycle after the commit.
REQ-035 Drop enable mid-DRIVE -> next cycle an=0, seg=0. Re-enable -> frame_start pulses and scanning resumes at digit 0.
REQ-036 Display 16'h0007 -> with SEG_LEADING_ZERO_BLANK_EN, digits 3..1 give seg=00 and digit 0 gives seg=07. Without the macro, digits 3..1 give seg=3F.
REQ-037 Assert reset with a pending update mid-frame -> all outputs at reset values, display=0000, pending discarded.
